sat_search_controller: RTL and testbench
========================================

# sat_search_controller

Search sequencer for the SAT solver datapath. It drives the assignment table through `at_address` writes and runs a depth-first decide / propagate / backtrack loop over the variable set. It hands each propagation round to the external BCP unit through a request/acknowledge handshake and reports a SAT or UNSAT verdict. It replaces the free-running decision counter with a decision stack, so conflicts can be resolved by flipping or undoing decisions.

## Interface

- `VAR_NUM`, default 20: number of variables, 1..31.
- `AW`, default 12: assignment-table address width. The variable index is zero-extended to this width.
- `LW`, default 5: decision-level width. Must satisfy 2^LW > VAR_NUM.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a search. Accepted only in IDLE, DONE_SAT or DONE_UNSAT.
- `at_wr_en` out 1: one-cycle assignment-table write strobe.
- `at_address` out AW: variable index being written.
- `at_wr_value` out 1: polarity written. Meaningful only when `at_wr_clr`=0.
- `at_wr_clr` out 1: qualifies `at_wr_en`. When set, the write marks the variable unassigned.
- `bcp_req` out 1: propagation request. Held high until acknowledged.
- `bcp_ack` in 1: one-cycle completion pulse from the BCP unit.
- `bcp_conflict` in 1: conflict flag. Sampled only in a cycle where `bcp_ack`=1.
- `bt_pulse` out 1: one-cycle backtrack notice to the BCP unit. The unit undoes all implications above `level`.
- `level` out LW: current decision level.
- `busy` out 1: high in every state except IDLE, DONE_SAT and DONE_UNSAT.
- `dp_sat` out 1: high in DONE_SAT.
- `dp_unsat` out 1: high in DONE_UNSAT.

## Operation

- Internal state:
  - `assigned[VAR_NUM]` and `value[VAR_NUM]` bit vectors.
  - Decision stack of depth VAR_NUM; each entry is {var index, flipped}.
  - `level` equals the stack occupancy.
- States: IDLE, PROP, WAIT, PICK, WRITE, BACKTRACK, DONE_SAT, DONE_UNSAT.
- **IDLE / DONE_\*** on `start`: clear `assigned`, `value` and the stack, set `level`=0, go to PROP. This performs initial unit propagation at level 0.
- **PROP**: assert `bcp_req`, go to WAIT.
- **WAIT**: hold `bcp_req` high.
  - On `bcp_ack` with `bcp_conflict`=1: go to BACKTRACK, or to DONE_UNSAT if `level`=0.
  - On `bcp_ack` with `bcp_conflict`=0: go to PICK.
- **PICK**: priority-encode the lowest index i with `assigned[i]`=0.
  - If none exists, go to DONE_SAT.
  - Otherwise push {i, 0}, set `assigned[i]`=1 and `value[i]`=0, increment `level`, go to WRITE.
- **WRITE**: pulse `at_wr_en` with `at_address`=i, `at_wr_value`=`value[i]`, `at_wr_clr`=0, then go to PROP.
- **BACKTRACK**, with top entry {i, f}:
  - f=0: set flipped=1 and `value[i]`=1, pulse `bt_pulse` with `level` unchanged, go to WRITE. WRITE writes value 1.
  - f=1: pop, clear `assigned[i]`, pulse `at_wr_en` with `at_wr_clr`=1 and `at_address`=i, decrement `level`, pulse `bt_pulse`.
    - If the new `level`=0, go to DONE_UNSAT.
    - Otherwise stay in BACKTRACK and examine the new top next cycle.
- `start` outside IDLE/DONE_\* is ignored.
- `bcp_ack` outside WAIT is ignored.
- The stack cannot overflow: a push only occurs when an unassigned variable exists.

## Timing

- Reset is asynchronous, active-low. While `rst`=0:
  - The FSM is in IDLE.
  - All outputs are 0, `level`=0, and the stack is empty.
  - `bcp_req` drops immediately, even in the middle of a handshake.
- All outputs are registered.
- `start` → `bcp_req` high: 2 cycles (PROP is entered at edge 1; `bcp_req` is registered at edge 2).
- `bcp_ack` may arrive in the first cycle `bcp_req` is high. `bcp_req` is low in the cycle after the ack is sampled.
- No conflict, per decision: PICK 1 cycle, WRITE 1 cycle, PROP 1 cycle, then WAIT.
- With a zero-latency BCP (ack in the first `bcp_req` cycle), one decision takes 4 cycles.
- Each BACKTRACK step takes 1 cycle. A flip reaches `bcp_req` 3 cycles after entering BACKTRACK.
- `dp_sat` and `dp_unsat` stay high until the next accepted `start` or reset.
- `at_wr_en` and `bt_pulse` are never high for more than one consecutive cycle per stack operation.

## Test plan

- **Reset mid-WAIT:** assert `rst`=0 while `bcp_req`=1. Required: `bcp_req`, `busy`, `level` and `at_wr_en` are 0 asynchronously; after release the block is idle and `dp_sat`=`dp_unsat`=0.
- **No conflicts, VAR_NUM=3, zero-latency BCP:** `start`. Required: writes to addresses 0, 1, 2 with value 0 in that order; `level` steps 1, 2, 3; `dp_sat`=1 after the fourth BCP round; `dp_unsat` stays 0.
- **Single flip:** conflict only on the round following the var-0=0 write. Required: `bt_pulse` fires, address 0 is rewritten with value 1 at `level`=1, then the search proceeds to SAT.
- **Always-conflict, VAR_NUM=2:** every BCP round after level 0 reports a conflict. Required:
  - Sequence: var0=0 conflict → flip to var0=1 conflict → clear write on address 0 (`at_wr_clr`=1) → `level`=0 → `dp_unsat`=1.
  - Conflict in the initial level-0 round → `dp_unsat` immediately, with no table writes.
- **Handshake robustness:** ack delayed 5 cycles; spurious `bcp_ack` while in PICK. Required: `bcp_req` is held for exactly 5 cycles; the spurious ack has no effect.
- **Start while busy:** pulse `start` during WAIT. Required: ignored, no stack change. A `start` in DONE_SAT restarts the search with `level`=0 and a fresh level-0 BCP round.

Source files
------------

// File: rtl/sat_search_controller.sv
// Depth-first SAT search sequencer.
// Runs a decide / propagate / backtrack loop over VAR_NUM variables, driving the
// assignment table and handing each propagation round to an external BCP unit.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start                    begin a search (accepted only when not busy)
//   at_wr_en/at_address/
//   at_wr_value/at_wr_clr    assignment-table write strobe, address, polarity, clear
//   bcp_req/bcp_ack/
//   bcp_conflict             propagation handshake and conflict flag
//   bt_pulse                 backtrack notice; BCP undoes implications above level
//   level                    current decision level (= decision stack occupancy)
//   busy, dp_sat, dp_unsat   status / verdict
module sat_search_controller #(
  parameter int unsigned VAR_NUM = 20,
  parameter int unsigned AW      = 12,
  parameter int unsigned LW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          at_wr_en,
  output logic [AW-1:0] at_address,
  output logic          at_wr_value,
  output logic          at_wr_clr,
  output logic          bcp_req,
  input  logic          bcp_ack,
  input  logic          bcp_conflict,
  output logic          bt_pulse,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          dp_sat,
  output logic          dp_unsat
);

  localparam int unsigned IW = (VAR_NUM > 1) ? $clog2(VAR_NUM) : 1;

  typedef enum logic [2:0] {
    StIdle, StProp, StWait, StPick, StWrite, StBacktrack, StDoneSat, StDoneUnsat
  } state_e;

  state_e state_q, state_d;

  logic [VAR_NUM-1:0] assigned_q, assigned_d;
  logic [VAR_NUM-1:0] value_q, value_d;
  logic [VAR_NUM-1:0] stk_flip_q, stk_flip_d;
  logic [IW-1:0]      stk_var_q [VAR_NUM];
  logic [IW-1:0]      stk_var_d [VAR_NUM];
  logic [LW-1:0]      level_q, level_d;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_val_q, wr_val_d;
  logic          wr_clr_q, wr_clr_d;
  logic          req_q, req_d;
  logic          bt_q, bt_d;
  logic          busy_q, busy_d;
  logic          sat_q, sat_d;
  logic          unsat_q, unsat_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] push_pos, top_pos, top_var;
  logic          top_flip;

  // Lowest-index unassigned variable.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = int'(VAR_NUM) - 1; i >= 0; i--) begin
      if (!assigned_q[i]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  assign push_pos = IW'(level_q);
  assign top_pos  = IW'(level_q - LW'(1));
  assign top_var  = stk_var_q[top_pos];
  assign top_flip = stk_flip_q[top_pos];

  always_comb begin
    state_d    = state_q;
    assigned_d = assigned_q;
    value_d    = value_q;
    stk_flip_d = stk_flip_q;
    stk_var_d  = stk_var_q;
    level_d    = level_q;
    wr_en_d    = 1'b0;
    addr_d     = '0;
    wr_val_d   = 1'b0;
    wr_clr_d   = 1'b0;
    bt_d       = 1'b0;

    unique case (state_q)
      StIdle, StDoneSat, StDoneUnsat: begin
        if (start) begin
          assigned_d = '0;
          value_d    = '0;
          stk_flip_d = '0;
          level_d    = '0;
          state_d    = StProp;
        end
      end
      StProp: state_d = StWait;
      StWait: begin
        if (bcp_ack) begin
          if (!bcp_conflict)        state_d = StPick;
          else if (level_q == '0)   state_d = StDoneUnsat;
          else                      state_d = StBacktrack;
        end
      end
      StPick: begin
        if (!pick_found) begin
          state_d = StDoneSat;
        end else begin
          stk_var_d[push_pos]  = pick_idx;
          stk_flip_d[push_pos] = 1'b0;
          assigned_d[pick_idx] = 1'b1;
          value_d[pick_idx]    = 1'b0;
          level_d              = level_q + LW'(1);
          wr_en_d              = 1'b1;
          addr_d               = AW'(pick_idx);
          wr_val_d             = 1'b0;
          state_d              = StWrite;
        end
      end
      StWrite: state_d = StProp;
      StBacktrack: begin
        bt_d    = 1'b1;
        wr_en_d = 1'b1;
        addr_d  = AW'(top_var);
        if (!top_flip) begin
          // Try the other polarity at the same level.
          stk_flip_d[top_pos] = 1'b1;
          value_d[top_var]    = 1'b1;
          wr_val_d            = 1'b1;
          state_d             = StWrite;
        end else begin
          // Both polarities exhausted: undo this decision.
          assigned_d[top_var] = 1'b0;
          wr_clr_d            = 1'b1;
          level_d             = level_q - LW'(1);
          if (level_q == LW'(1)) state_d = StDoneUnsat;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are derived from the next state.
    req_d   = (state_d == StWait);
    sat_d   = (state_d == StDoneSat);
    unsat_d = (state_d == StDoneUnsat);
    busy_d  = !(state_d == StIdle || state_d == StDoneSat || state_d == StDoneUnsat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      assigned_q <= '0;
      value_q    <= '0;
      stk_flip_q <= '0;
      for (int i = 0; i < int'(VAR_NUM); i++) stk_var_q[i] <= '0;
      level_q    <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_val_q   <= 1'b0;
      wr_clr_q   <= 1'b0;
      req_q      <= 1'b0;
      bt_q       <= 1'b0;
      busy_q     <= 1'b0;
      sat_q      <= 1'b0;
      unsat_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      assigned_q <= assigned_d;
      value_q    <= value_d;
      stk_flip_q <= stk_flip_d;
      stk_var_q  <= stk_var_d;
      level_q    <= level_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wr_val_q   <= wr_val_d;
      wr_clr_q   <= wr_clr_d;
      req_q      <= req_d;
      bt_q       <= bt_d;
      busy_q     <= busy_d;
      sat_q      <= sat_d;
      unsat_q    <= unsat_d;
    end
  end

  assign at_wr_en    = wr_en_q;
  assign at_address  = addr_q;
  assign at_wr_value = wr_val_q;
  assign at_wr_clr   = wr_clr_q;
  assign bcp_req     = req_q;
  assign bt_pulse    = bt_q;
  assign level       = level_q;
  assign busy        = busy_q;
  assign dp_sat      = sat_q;
  assign dp_unsat    = unsat_q;

endmodule

// File: tb/tb_sat_search_controller.sv
// Scoreboard bench for sat_search_controller. A BCP responder decides conflicts from a
// set of nogoods applied to its own copy of the assignment table; a DPLL reference
// model predicts the table writes, BCP rounds and verdict.
module tb_sat_search_controller;
  localparam int unsigned NV = 3;
  localparam int unsigned AW = 12;
  localparam int unsigned LW = 5;

  localparam int K_BCP = 0, K_WR = 1, K_SAT = 2, K_UNSAT = 3, K_BT = 4;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic          bcp_ack = 1'b0, bcp_conflict = 1'b0;
  logic          at_wr_en, at_wr_value, at_wr_clr, bcp_req, bt_pulse, busy, dp_sat, dp_unsat;
  logic [AW-1:0] at_address;
  logic [LW-1:0] level;

  sat_search_controller #(.VAR_NUM(NV), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .at_wr_en(at_wr_en), .at_address(at_address), .at_wr_value(at_wr_value),
    .at_wr_clr(at_wr_clr), .bcp_req(bcp_req), .bcp_ack(bcp_ack),
    .bcp_conflict(bcp_conflict), .bt_pulse(bt_pulse), .level(level), .busy(busy),
    .dp_sat(dp_sat), .dp_unsat(dp_unsat)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int val; int clr; int bt; int lvl; } ev_t;
  ev_t exp_q[$];
  int  ng_mask[$], ng_val[$];
  int  rise_cyc[$];
  int  errors = 0, checks = 0, cyc = 0;
  int  fixed_delay = -1;
  bit  ack_en = 1'b1, spur_en = 1'b0;
  int  mir_a = 0, mir_v = 0;
  logic prev_req = 1'b0, prev_sat = 1'b0, prev_unsat = 1'b0, prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic bit conflict_of(input int amask, input int vals);
    for (int i = 0; i < ng_mask.size(); i++)
      if ((ng_mask[i] & amask) == ng_mask[i] && ((vals ^ ng_val[i]) & ng_mask[i]) == 0)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void push_ev(input int k, input int a, input int v, input int c,
                                  input int b, input int l);
    ev_t e;
    e.kind = k; e.addr = a; e.val = v; e.clr = c; e.bt = b; e.lvl = l;
    exp_q.push_back(e);
  endfunction

  // Plain DPLL over the nogood oracle: decide lowest free var = 0, on conflict flip,
  // undo flipped decisions, give up when no decision remains.
  task automatic build_expected();
    int amask = 0, vals = 0, v;
    int sv[$];
    bit sf[$];
    push_ev(K_BCP, 0, 0, 0, 0, 0);
    if (conflict_of(0, 0)) begin push_ev(K_UNSAT, 0, 0, 0, 0, 0); return; end
    while (1) begin
      v = -1;
      for (int i = NV - 1; i >= 0; i--) if (((amask >> i) & 1) == 0) v = i;
      if (v < 0) begin push_ev(K_SAT, 0, 0, 0, 0, sv.size()); return; end
      amask |= (1 << v);
      vals &= ~(1 << v);
      sv.push_back(v); sf.push_back(1'b0);
      push_ev(K_WR, v, 0, 0, 0, sv.size());
      push_ev(K_BCP, 0, 0, 0, 0, sv.size());
      while (conflict_of(amask, vals)) begin
        while (sf[sf.size()-1]) begin
          v = sv.pop_back(); void'(sf.pop_back());
          amask &= ~(1 << v);
          push_ev(K_WR, v, 0, 1, 1, sv.size());
          if (sv.size() == 0) begin push_ev(K_UNSAT, 0, 0, 0, 0, 0); return; end
        end
        v = sv[sv.size()-1];
        sf[sf.size()-1] = 1'b1;
        vals |= (1 << v);
        push_ev(K_WR, v, 1, 0, 1, sv.size());
        push_ev(K_BCP, 0, 0, 0, 0, sv.size());
      end
    end
  endtask

  task automatic observe(input ev_t a);
    ev_t e;
    bit  bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d val=%0d clr=%0d bt=%0d lvl=%0d, required none",
               a.kind, a.addr, a.val, a.clr, a.bt, a.lvl);
      return;
    end
    e = exp_q.pop_front();
    bad = (a.kind != e.kind) || (a.addr != e.addr) || (a.clr != e.clr) || (a.bt != e.bt) ||
          (a.lvl != e.lvl) || (e.kind == K_WR && e.clr == 0 && a.val != e.val);
    if (bad) begin
      errors++;
      $display("FAIL event: got kind=%0d addr=%0d val=%0d clr=%0d bt=%0d lvl=%0d, required kind=%0d addr=%0d val=%0d clr=%0d bt=%0d lvl=%0d",
               a.kind, a.addr, a.val, a.clr, a.bt, a.lvl, e.kind, e.addr, e.val, e.clr, e.bt, e.lvl);
    end
  endtask

  // Monitor: turns DUT activity into events and keeps the BCP unit's table copy.
  always @(negedge clk) begin
    ev_t a;
    if (rst) begin
      if (bcp_req && !prev_req) begin
        a.kind = K_BCP; a.addr = 0; a.val = 0; a.clr = 0; a.bt = 0; a.lvl = int'(level);
        observe(a);
        rise_cyc.push_back(cyc);
      end
      if (at_wr_en || bt_pulse) begin
        a.kind = at_wr_en ? K_WR : K_BT; a.addr = int'(at_address); a.val = int'(at_wr_value);
        a.clr = int'(at_wr_clr); a.bt = int'(bt_pulse); a.lvl = int'(level);
        observe(a);
      end
      if (dp_sat && !prev_sat) begin
        a.kind = K_SAT; a.addr = 0; a.val = 0; a.clr = 0; a.bt = 0; a.lvl = int'(level);
        observe(a);
      end
      if (dp_unsat && !prev_unsat) begin
        a.kind = K_UNSAT; a.addr = 0; a.val = 0; a.clr = 0; a.bt = 0; a.lvl = int'(level);
        observe(a);
      end
      if (busy && !prev_busy) begin
        mir_a <= 0; mir_v <= 0;
      end else if (at_wr_en) begin
        if (at_wr_clr) mir_a <= mir_a & ~(1 << at_address);
        else begin
          mir_a <= mir_a | (1 << at_address);
          mir_v <= at_wr_value ? (mir_v | (1 << at_address)) : (mir_v & ~(1 << at_address));
        end
      end
    end
    prev_req   <= bcp_req;
    prev_sat   <= dp_sat;
    prev_unsat <= dp_unsat;
    prev_busy  <= busy;
  end

  // BCP responder.
  initial begin
    int d, held;
    forever begin
      @(negedge clk);
      bcp_ack = 1'b0;
      if (rst && bcp_req && ack_en) begin
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        held = 1;
        repeat (d) begin
          @(negedge clk);
          if (bcp_req) held++;
        end
        bcp_conflict = conflict_of(mir_a, mir_v);
        bcp_ack = 1'b1;
        @(negedge clk);
        bcp_ack = 1'b0;
        bcp_conflict = 1'($urandom_range(0, 1));
        check("req_low_after_ack", int'(bcp_req), 0);
        if (fixed_delay == 4) check("req_held_cycles", held, 5);
      end else if (rst && spur_en && !bcp_req && $urandom_range(0, 2) == 0) begin
        bcp_conflict = 1'($urandom_range(0, 1));
        bcp_ack = 1'b1;
      end
    end
  end

  task automatic run_search(input string name);
    int exp_lvl;
    build_expected();
    exp_lvl = exp_q[exp_q.size()-1].lvl;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_level_after_start"}, int'(level), 0);
    check({name, "_req_after_1"}, int'(bcp_req), 0);
    @(negedge clk);
    check({name, "_req_after_2"}, int'(bcp_req), 1);
    for (int k = 0; k < 3000 && !(dp_sat || dp_unsat); k++) @(negedge clk);
    check({name, "_done"}, int'(dp_sat || dp_unsat), 1);
    repeat (2) @(negedge clk);
    check({name, "_events_left"}, exp_q.size(), 0);
    check({name, "_final_level"}, int'(level), exp_lvl);
    check({name, "_busy"}, int'(busy), 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(bcp_req), 0);
    check("rst_level", int'(level), 0);
    check("rst_verdict", int'(dp_sat || dp_unsat || at_wr_en || bt_pulse), 0);
    rst = 1'b1;

    // No conflicts, zero-latency BCP.
    fixed_delay = 0;
    rise_cyc.delete();
    run_search("noconf");
    check("noconf_rounds", rise_cyc.size(), 4);
    if (rise_cyc.size() >= 2) check("decision_cycles", rise_cyc[1] - rise_cyc[0], 4);
    check("noconf_sat", int'(dp_sat), 1);
    check("noconf_unsat", int'(dp_unsat), 0);

    // Reset in the middle of a handshake.
    ack_en = 1'b0;
    push_ev(K_BCP, 0, 0, 0, 0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && !bcp_req; k++) @(negedge clk);
    check("midwait_req_seen", int'(bcp_req), 1);
    #2 rst = 1'b0;
    #1;
    check("async_req", int'(bcp_req), 0);
    check("async_busy", int'(busy), 0);
    check("async_level", int'(level), 0);
    check("async_wr_en", int'(at_wr_en), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", int'(busy || bcp_req), 0);
    check("post_rst_verdict", int'(dp_sat || dp_unsat), 0);
    check("post_rst_events", exp_q.size(), 0);
    exp_q.delete();
    ack_en = 1'b1;

    // Single flip on var0.
    ng_mask = '{1}; ng_val = '{0};
    run_search("flip");
    check("flip_sat", int'(dp_sat), 1);

    // Both polarities of var0 conflict.
    ng_mask = '{1, 1}; ng_val = '{0, 1};
    run_search("allconf");
    check("allconf_unsat", int'(dp_unsat), 1);

    // Conflict already at level 0.
    ng_mask = '{0}; ng_val = '{0};
    run_search("lvl0conf");
    check("lvl0_unsat", int'(dp_unsat), 1);

    // Slow BCP, spurious acks, start while busy.
    ng_mask = '{1}; ng_val = '{0};
    fixed_delay = 4;
    spur_en = 1'b1;
    fork
      run_search("slow");
      begin
        int k;
        for (k = 0; k < 200 && !(bcp_req && level == LW'(1)); k++) @(negedge clk);
        check("busy_start_window", int'(bcp_req && level == LW'(1)), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_level", int'(level), 1);
        check("busy_start_busy", int'(busy), 1);
      end
    join

    // Restart from DONE_SAT.
    ng_mask.delete(); ng_val.delete();
    run_search("restart");

    // Randomized nogood sets and BCP latency.
    fixed_delay = -1;
    for (int t = 0; t < 25; t++) begin
      int n;
      ng_mask.delete(); ng_val.delete();
      n = int'($urandom_range(0, 4));
      for (int j = 0; j < n; j++) begin
        ng_mask.push_back(int'($urandom_range(1, 7)));
        ng_val.push_back(int'($urandom_range(0, 7)));
      end
      run_search("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
